// File: rtl/chess_time_bank.sv
// Per-player minutes:seconds countdown bank for a chess clock.
// Only the active player counts down; the first player to reach 0:00 freezes the bank.
module chess_time_bank #(
    parameter int NUM_PLAYERS = 2,
    parameter int MIN_W       = 8,
    parameter int INC_SEC     = 0,
    localparam int FW         = MIN_W + 6,
    localparam int AW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_time,
    input  logic [MIN_W-1:0]          time_in,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      switch_player,
    output logic [NUM_PLAYERS*FW-1:0] data_out,
    output logic [AW-1:0]             active_player,
    output logic                      running,
    output logic                      timeout,
    output logic [AW-1:0]             flag_player
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_TIMEOUT} state_t;

    state_t           r_state, w_state_next;
    logic [AW-1:0]    r_active, w_active_next, w_active_inc;
    logic [AW-1:0]    r_flag, w_flag_next;
    logic [MIN_W-1:0] r_min [NUM_PLAYERS];
    logic [5:0]       r_sec [NUM_PLAYERS];

    logic [MIN_W-1:0] w_cur_min, w_dec_min, w_base_min, w_inc_min, w_new_min;
    logic [5:0]       w_cur_sec, w_dec_sec, w_base_sec, w_inc_sec, w_new_sec;
    logic [6:0]       w_sum;
    logic             w_cur_zero, w_dec_zero, w_wr_en;

    assign w_cur_min    = r_min[r_active];
    assign w_cur_sec    = r_sec[r_active];
    assign w_cur_zero   = (w_cur_min == '0) && (w_cur_sec == '0);
    assign w_active_inc = (r_active == AW'(NUM_PLAYERS - 1)) ? '0 : r_active + 1'b1;

    always_comb begin
        w_dec_min = w_cur_min;
        w_dec_sec = w_cur_sec;
        if (w_cur_sec != '0) begin
            w_dec_sec = w_cur_sec - 6'd1;
        end else if (w_cur_min != '0) begin
            w_dec_min = w_cur_min - MIN_W'(1);
            w_dec_sec = 6'd59;
        end
    end

    assign w_dec_zero = (w_dec_min == '0) && (w_dec_sec == '0);

    // The increment applies on top of a same-cycle decrement.
    assign w_base_min = tick ? w_dec_min : w_cur_min;
    assign w_base_sec = tick ? w_dec_sec : w_cur_sec;
    assign w_sum      = {1'b0, w_base_sec} + 7'(INC_SEC);

    always_comb begin
        w_inc_min = w_base_min;
        w_inc_sec = w_sum[5:0];
        if (w_sum >= 7'd60) begin
            if (&w_base_min) begin
                w_inc_sec = 6'd59;
            end else begin
                w_inc_min = w_base_min + MIN_W'(1);
                w_inc_sec = 6'(w_sum - 7'd60);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_active_next = r_active;
        w_flag_next   = r_flag;
        w_wr_en       = 1'b0;
        w_new_min     = w_cur_min;
        w_new_sec     = w_cur_sec;
        if (set_time) begin
            w_state_next  = S_IDLE;
            w_active_next = '0;
            w_flag_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (switch_player) w_active_next = w_active_inc;
                    if (start && !w_cur_zero) w_state_next = S_RUN;
                end
                S_RUN: begin
                    if (tick && w_dec_zero) begin
                        w_wr_en      = 1'b1;
                        w_new_min    = w_dec_min;
                        w_new_sec    = w_dec_sec;
                        w_state_next = S_TIMEOUT;
                        w_flag_next  = r_active;
                    end else begin
                        if (switch_player) begin
                            w_wr_en       = 1'b1;
                            w_new_min     = w_inc_min;
                            w_new_sec     = w_inc_sec;
                            w_active_next = w_active_inc;
                        end else if (tick) begin
                            w_wr_en   = 1'b1;
                            w_new_min = w_dec_min;
                            w_new_sec = w_dec_sec;
                        end
                        if (pause) w_state_next = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start && !pause) w_state_next = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_active <= '0;
            r_flag   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_active <= w_active_next;
            r_flag   <= w_flag_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_min[p] <= '0;
                r_sec[p] <= '0;
            end
        end else if (set_time) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_min[p] <= time_in;
                r_sec[p] <= '0;
            end
        end else if (w_wr_en) begin
            r_min[r_active] <= w_new_min;
            r_sec[r_active] <= w_new_sec;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pack
            assign data_out[gi*FW +: FW] = {r_min[gi], r_sec[gi]};
        end
    endgenerate

    assign active_player = r_active;
    assign flag_player   = r_flag;
    assign running       = (r_state == S_RUN);
    assign timeout       = (r_state == S_TIMEOUT);

endmodule
